// File: rtl/word_collector.sv
// word_collector
//   Skips whitespace in an 8-bit character stream and assembles the next
//   whitespace-delimited token into a character buffer. The token and its
//   length are handed to the number converter over a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_char, i_valid      incoming character stream
//   o_ready              character accepted on edges with i_valid & o_ready
//   o_word               token buffer, char k at [8k+7:8k], char 0 first
//   o_len                valid characters in o_word (0..WIDTH)
//   o_valid, i_ready     token handshake
//   o_err                token was truncated; meaningful only with o_valid
module word_collector #(
    parameter  int WIDTH      = 32,
    localparam int WIDTH_BITS = $clog2(WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_char,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [8*WIDTH-1:0]    o_word,
    output logic [WIDTH_BITS-1:0] o_len,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    localparam logic [WIDTH_BITS-1:0] LEN_MAX = WIDTH_BITS'(WIDTH);

    state_t                   state, next_state;
    logic [WIDTH-1:0][7:0]    word;
    logic [WIDTH_BITS-1:0]    len;
    logic                     overflow;
    logic                     is_ws;
    logic                     accept;

    assign is_ws   = (i_char == 8'h20) || (i_char == 8'h09) ||
                     (i_char == 8'h0A) || (i_char == 8'h0D);
    assign o_ready = (state != HOLD);
    assign accept  = i_valid && o_ready;
    assign o_valid = (state == HOLD);
    // The flag is only exposed while the token is presented.
    assign o_err   = (state == HOLD) && overflow;
    assign o_word  = word;
    assign o_len   = len;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && !is_ws) next_state = COLLECT;
            COLLECT: if (accept && is_ws)  next_state = HOLD;
            HOLD:    if (i_ready)          next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Buffer is cleared on every handshake and filled strictly in order, so
    // IDLE always starts at len==0 and slots at or above len stay zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word     <= '0;
            len      <= '0;
            overflow <= 1'b0;
        end else if (state == HOLD) begin
            if (i_ready) begin
                word     <= '0;
                len      <= '0;
                overflow <= 1'b0;
            end
        end else if (accept && !is_ws) begin
            if (len < LEN_MAX) begin
                for (int k = 0; k < WIDTH; k++) begin
                    if (len == WIDTH_BITS'(k)) word[k] <= i_char;
                end
                len <= len + WIDTH_BITS'(1);
            end else begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
